// File: rtl/pim_mem_responder.sv
// Memory-side responder for the PIM control unit's strobe/ready handshake.
// Optional build macro PIM_MEM_PARITY_EN adds a stored even-parity bit and a parity_err output.
module pim_mem_responder #(
  parameter int ADDR_W       = 10,
  parameter int LATENCY      = 4,
  parameter int READY_CYCLES = 2,
  parameter int SYNC_STAGES  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] memory_address,
  input  logic [31:0]       data_in,
  input  logic              memory_read,
  input  logic              memory_write,
`ifdef PIM_MEM_PARITY_EN
  input  logic              parity_inject,
  output logic              parity_err,
`endif
  output logic [31:0]       data_out,
  output logic              mem_ready,
  output logic              busy,
  output logic              overrun,
  output logic              conflict
);

  localparam int WORDS = 2 ** ADDR_W;
`ifdef PIM_MEM_PARITY_EN
  localparam int MEM_W = 33;
`else
  localparam int MEM_W = 32;
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_RESPOND
  } state_t;

  state_t r_state, w_state_nxt;
  logic [3:0] r_cnt, w_cnt_nxt;

  logic [SYNC_STAGES-1:0] r_rd_sync, r_wr_sync;
  logic r_rd_q, r_wr_q;
  logic w_rd_rise, w_wr_rise;

  logic w_latch, w_do_access, w_overrun_set, w_conflict_set;

  logic [ADDR_W-1:0] r_addr_q;
  logic [31:0]       r_wdata_q;
  logic              r_op_wr;
  logic [31:0]       r_data_out;
  logic              r_overrun, r_conflict;

  logic [MEM_W-1:0] r_mem [WORDS];
  logic [MEM_W-1:0] w_wr_word, w_rd_word;

  // Strobes may be asynchronous to clk; the last sync stage feeds the edge flop.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_sync <= '0;
      r_wr_sync <= '0;
      r_rd_q    <= 1'b0;
      r_wr_q    <= 1'b0;
    end else begin
      r_rd_sync[0] <= memory_read;
      r_wr_sync[0] <= memory_write;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_rd_sync[i] <= r_rd_sync[i-1];
        r_wr_sync[i] <= r_wr_sync[i-1];
      end
      r_rd_q <= r_rd_sync[SYNC_STAGES-1];
      r_wr_q <= r_wr_sync[SYNC_STAGES-1];
    end
  end

  assign w_rd_rise = r_rd_sync[SYNC_STAGES-1] & ~r_rd_q;
  assign w_wr_rise = r_wr_sync[SYNC_STAGES-1] & ~r_wr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_latch        = 1'b0;
    w_do_access    = 1'b0;
    w_overrun_set  = 1'b0;
    w_conflict_set = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_rd_rise && w_wr_rise) begin
          w_conflict_set = 1'b1;
        end else if (w_rd_rise || w_wr_rise) begin
          w_latch     = 1'b1;
          w_cnt_nxt   = 4'(LATENCY - 1);
          w_state_nxt = S_ACCESS;
        end
      end
      S_ACCESS: begin
        w_overrun_set = w_rd_rise | w_wr_rise;
        if (r_cnt != 4'd0) begin
          w_cnt_nxt = r_cnt - 4'd1;
        end else begin
          w_do_access = 1'b1;
          w_cnt_nxt   = 4'(READY_CYCLES - 1);
          w_state_nxt = S_RESPOND;
        end
      end
      S_RESPOND: begin
        w_overrun_set = w_rd_rise | w_wr_rise;
        if (r_cnt != 4'd0) begin
          w_cnt_nxt = r_cnt - 4'd1;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

`ifdef PIM_MEM_PARITY_EN
  assign w_wr_word = {(^r_wdata_q) ^ parity_inject, r_wdata_q};
`else
  assign w_wr_word = r_wdata_q;
`endif
  assign w_rd_word = r_mem[r_addr_q];

  // NOTE: the array has no reset; contents survive rst and it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (w_do_access && r_op_wr) begin
      r_mem[r_addr_q] <= w_wr_word;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr_q   <= '0;
      r_wdata_q  <= '0;
      r_op_wr    <= 1'b0;
      r_data_out <= '0;
      r_overrun  <= 1'b0;
      r_conflict <= 1'b0;
    end else begin
      if (w_latch) begin
        r_addr_q  <= memory_address;
        r_wdata_q <= data_in;
        r_op_wr   <= w_wr_rise;
      end
      if (w_do_access && !r_op_wr) begin
        r_data_out <= w_rd_word[31:0];
      end
      if (w_overrun_set) r_overrun <= 1'b1;
      if (w_conflict_set) r_conflict <= 1'b1;
    end
  end

`ifdef PIM_MEM_PARITY_EN
  logic r_parity_err;

  // A stored word with odd total parity indicates corruption.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_parity_err <= 1'b0;
    end else if (w_do_access && !r_op_wr) begin
      r_parity_err <= ^w_rd_word;
    end
  end

  assign parity_err = r_parity_err;
`endif

  assign data_out  = r_data_out;
  assign mem_ready = (r_state == S_RESPOND);
  assign busy      = (r_state != S_IDLE);
  assign overrun   = r_overrun;
  assign conflict  = r_conflict;

endmodule

// File: doc/pim_mem_responder.md
Name: pim_mem_responder

Overview:
- Memory-side responder for the PIM control unit's memory strobe/ready handshake.
- Owns a WORDS x 32 storage array.
- Detects rising edges of the memory_read and memory_write strobes, performs the access after a fixed latency, and pulses mem_ready back to the control unit.
- Sits between the control unit (address, strobes), the write-data mux (data_in) and the ALU operand registers (data_out).

Parameters:
- ADDR_W, 10, address width; WORDS = 2**ADDR_W.
- LATENCY, 4, clk cycles from detected strobe edge to mem_ready rise; legal range 1..15.
- READY_CYCLES, 2, number of cycles mem_ready stays high; legal range 1..7.
- SYNC_STAGES, 2, synchronizer flops on memory_read/memory_write; legal range 1..3.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- memory_address  in  ADDR_W  access address
- data_in  in  32  write data from the write-data mux
- memory_read  in  1  read strobe; may be asynchronous to clk
- memory_write  in  1  write strobe; may be asynchronous to clk
- data_out  out  32  read data, held until the next read completes
- mem_ready  out  1  access-complete pulse
- busy  out  1  high while not IDLE
- overrun  out  1  sticky; a strobe edge arrived while busy
- conflict  out  1  sticky; read and write edges arrived in the same cycle

Behaviour:
- Reset (asynchronous, rst=1):
  - state=IDLE, data_out=0, mem_ready=0, busy=0, overrun=0, conflict=0.
  - Synchronizer and edge flops are cleared.
  - Array contents are NOT cleared.
- Strobe synchronization: each strobe passes through SYNC_STAGES flops.
  - rd_rise = rd_s & ~rd_s_q; wr_rise likewise.
- State IDLE:
  - rd_rise xor wr_rise: latch memory_address into addr_q, data_in into wdata_q, and the operation into op_q; cnt = LATENCY-1; go to ACCESS; busy=1.
  - rd_rise and wr_rise together: conflict=1 (sticky); no access; stay IDLE.
- State ACCESS:
  - cnt != 0: cnt decrements.
  - cnt == 0:
    - write: mem[addr_q] = wdata_q.
    - read: data_out = mem[addr_q].
    - Then mem_ready=1, cnt = READY_CYCLES-1, go to RESPOND.
- State RESPOND:
  - cnt != 0: cnt decrements.
  - cnt == 0: mem_ready=0, busy=0, go to IDLE.
- Timing:
  - Given the rise-detect cycle T, mem_ready rises on the clk edge at T+LATENCY and is high for exactly READY_CYCLES cycles.
  - data_out is valid in the same cycle mem_ready rises.
- Busy handling: any rd_rise or wr_rise while not IDLE sets overrun=1 (sticky), is dropped, and does not affect the access in flight.
- Edge requirement: a strobe held high across the return to IDLE does not start a new access; a fresh rising edge is required.
- Address and data are sampled only at the latch cycle; later changes do not affect the access in flight.
- Read-after-write to the same address returns the new value.
- Address wrap: none. Addresses are exactly ADDR_W bits; every value is legal.
- Reset mid-operation:
  - Aborts immediately and mem_ready drops.
  - A write whose ACCESS cnt==0 cycle has not been reached leaves the array unmodified.
- overrun and conflict clear only on rst.

Optional Feature:
- Macro: PIM_MEM_PARITY_EN.
- Defined:
  - Array is 33 bits wide; a write stores the even parity of wdata_q in bit 32.
  - A read recomputes parity and sets a new output port parity_err (1 bit).
  - parity_err is updated at each read completion, held until the next read completion, and is 0 on reset.
  - A test-only input parity_inject (1 bit), when high at write time, stores the inverted parity bit.
- Undefined: 32-bit array; parity_err and parity_inject ports do not exist.

Test Plan:
1. Reset, then write addr 10'h005 data 32'hDEADBEEF via a memory_write pulse.
   - mem_ready rises LATENCY=4 cycles after the synchronized edge and is high 2 cycles; busy drops with it.
   - Then read 10'h005: data_out=32'hDEADBEEF when mem_ready rises.
2. Back-to-back boundary addresses: write 10'h3FF=32'h1 and 10'h000=32'h2, then read both.
   - Returns 1 and 2 respectively; no aliasing.
3. ALU-style sequence: read A, read B, write C, each started after the previous mem_ready.
   - Three mem_ready pulses; mem[C] equals the data_in value; overrun stays 0.
4. Second memory_read edge raised 2 cycles into an access.
   - overrun=1; only one mem_ready pulse; the first access completes with the original address.
5. memory_read and memory_write rise on the same clk edge.
   - conflict=1; no mem_ready; array unchanged.
   - rst mid-write (during ACCESS cnt=2): mem_ready=0 and the old value remains on readback.
6. (PIM_MEM_PARITY_EN) Write 32'h00000001 with parity_inject=1, then read.
   - parity_err=1.
   - A clean rewrite followed by a read gives parity_err=0.
